// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: data-memory stalls with timeout, taken-branch
// flushes and load-use interlock, plus a saturating stalled-cycle counter.
module pipe_hazard_ctrl #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        IDEX_MemR,
   input  logic [4:0]  IDEX_Rt,
   input  logic [4:0]  IFID_Rs,
   input  logic [4:0]  IFID_Rt,
   input  logic        branch_taken,
   input  logic        EXMEM_MemR,
   input  logic        EXMEM_MemWr,
   input  logic        dmem_ack,
   output logic        dmem_req,
   output logic        PCWr,
   output logic        IFIDWr,
   output logic        IDEXWr,
   output logic        EXMEMWr,
   output logic        IFIDflush,
   output logic        IDEXflush,
   output logic        rstEXMEM,
   output logic        err,
   output logic [15:0] stall_cnt
);

   typedef enum logic [1:0] {RUN, MEMWAIT, ERR} state_t;

   // Stall position of the final allowed no-ack cycle. The RUN cycle that
   // first sees the unacknowledged request is position 0, the first MEMWAIT
   // cycle is position 1, so TIMEOUT counts every stalled cycle.
   localparam logic [8:0] LAST = 9'(TIMEOUT - 1);

   state_t     state, nxt;
   logic [7:0] wait_cnt;
   logic       mem_op, load_use;
   logic [8:0] wait_pos;

   assign mem_op   = EXMEM_MemR | EXMEM_MemWr;
   assign load_use = IDEX_MemR && (IDEX_Rt != 5'd0) &&
                     ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));
   // wait_cnt holds MEMWAIT cycles already spent, so this cycle is one more
   assign wait_pos = {1'b0, wait_cnt} + 9'd1;

   // Next-state and Mealy outputs; all outputs forced low while in reset
   always_comb begin
      nxt       = state;
      dmem_req  = 1'b0;
      PCWr      = 1'b0;
      IFIDWr    = 1'b0;
      IDEXWr    = 1'b0;
      EXMEMWr   = 1'b0;
      IFIDflush = 1'b0;
      IDEXflush = 1'b0;
      rstEXMEM  = 1'b0;
      case (state)
         RUN: begin
            if (mem_op && !dmem_ack) begin
               // memory stall wins over branch and load-use
               dmem_req = 1'b1;
               if (LAST == 9'd0) begin
                  nxt      = ERR;
                  rstEXMEM = 1'b1;
               end else begin
                  nxt = MEMWAIT;
               end
            end else begin
               dmem_req = mem_op;
               PCWr     = 1'b1;
               IFIDWr   = 1'b1;
               IDEXWr   = 1'b1;
               EXMEMWr  = 1'b1;
               if (branch_taken) begin
                  // the branch kills the dependent instruction anyway
                  IFIDflush = 1'b1;
                  IDEXflush = 1'b1;
               end else if (load_use) begin
                  PCWr      = 1'b0;
                  IFIDWr    = 1'b0;
                  IDEXflush = 1'b1;
               end
            end
         end
         MEMWAIT: begin
            dmem_req = 1'b1;
            if (dmem_ack) begin
               // release; branch/load-use are re-presented next cycle
               nxt     = RUN;
               PCWr    = 1'b1;
               IFIDWr  = 1'b1;
               IDEXWr  = 1'b1;
               EXMEMWr = 1'b1;
            end else if (wait_pos == LAST) begin
               nxt      = ERR;
               rstEXMEM = 1'b1;
            end
         end
         default: nxt = ERR;
      endcase
      if (!rst) begin
         nxt       = RUN;
         dmem_req  = 1'b0;
         PCWr      = 1'b0;
         IFIDWr    = 1'b0;
         IDEXWr    = 1'b0;
         EXMEMWr   = 1'b0;
         IFIDflush = 1'b0;
         IDEXflush = 1'b0;
         rstEXMEM  = 1'b0;
      end
   end

   // State register, timeout counter and sticky error flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= RUN;
         wait_cnt <= 8'd0;
         err      <= 1'b0;
      end else begin
         state <= nxt;
         if (state == RUN && nxt == MEMWAIT)
            wait_cnt <= 8'd0;
         else if (state == MEMWAIT && nxt == MEMWAIT)
            wait_cnt <= wait_cnt + 8'd1;
         if (nxt == ERR)
            err <= 1'b1;
      end
   end

   // Saturating count of cycles where the PC is held, excluding ERR
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cnt <= 16'd0;
      else if (state != ERR && !PCWr && stall_cnt != 16'hFFFF)
         stall_cnt <= stall_cnt + 16'd1;
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (TIMEOUT=4): single-cycle vector table
// followed by memory-stall, timeout, reset-abort and saturation sequences.
module tb_pipe_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        IDEX_MemR, branch_taken, EXMEM_MemR, EXMEM_MemWr, dmem_ack;
   logic [4:0]  IDEX_Rt, IFID_Rs, IFID_Rt;
   logic        dmem_req, PCWr, IFIDWr, IDEXWr, EXMEMWr;
   logic        IFIDflush, IDEXflush, rstEXMEM, err;
   logic [15:0] stall_cnt;
   logic [7:0]  outs;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.TIMEOUT(4)) dut (
      .clk(clk), .rst(rst),
      .IDEX_MemR(IDEX_MemR), .IDEX_Rt(IDEX_Rt), .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt),
      .branch_taken(branch_taken), .EXMEM_MemR(EXMEM_MemR), .EXMEM_MemWr(EXMEM_MemWr),
      .dmem_ack(dmem_ack), .dmem_req(dmem_req), .PCWr(PCWr), .IFIDWr(IFIDWr),
      .IDEXWr(IDEXWr), .EXMEMWr(EXMEMWr), .IFIDflush(IFIDflush), .IDEXflush(IDEXflush),
      .rstEXMEM(rstEXMEM), .err(err), .stall_cnt(stall_cnt)
   );

   // {dmem_req, PCWr, IFIDWr, IDEXWr, EXMEMWr, IFIDflush, IDEXflush, rstEXMEM}
   assign outs = {dmem_req, PCWr, IFIDWr, IDEXWr, EXMEMWr, IFIDflush, IDEXflush, rstEXMEM};

   typedef struct {
      logic       ld;
      logic [4:0] rt_ex, rs_id, rt_id;
      logic       br, memr, memwr, ack;
      logic [7:0] exp;
      logic [15:0] sc;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ld, input logic [4:0] rt_ex, input logic [4:0] rs_id,
                        input logic [4:0] rt_id, input logic br, input logic memr,
                        input logic memwr, input logic ack);
      IDEX_MemR = ld; IDEX_Rt = rt_ex; IFID_Rs = rs_id; IFID_Rt = rt_id;
      branch_taken = br; EXMEM_MemR = memr; EXMEM_MemWr = memwr; dmem_ack = ack;
   endtask

   // advance to one time unit after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h78, 16'd0};
      vecs[1] = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1A, 16'd1};
      vecs[2] = '{1'b0, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h78, 16'd1};
      vecs[3] = '{1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h1A, 16'd2};
      vecs[4] = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7E, 16'd2};
      vecs[5] = '{1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h78, 16'd2};
      vecs[6] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h7E, 16'd2};
      vecs[7] = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hF8, 16'd2};
      vecs[8] = '{1'b1, 5'd7, 5'd7, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h9A, 16'd3};
      vecs[9] = '{1'b1, 5'd3, 5'd4, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h78, 16'd3};

      // reset state
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      check("reset_outs", outs, 8'h00);
      check("reset_err", err, 0);
      check("reset_cnt", stall_cnt, 0);
      step();
      step();
      rst = 1'b1;

      // single-cycle vectors in RUN
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].ld, vecs[i].rt_ex, vecs[i].rs_id, vecs[i].rt_id,
               vecs[i].br, vecs[i].memr, vecs[i].memwr, vecs[i].ack);
         #2;
         check($sformatf("vec%0d_outs", i), outs, vecs[i].exp);
         step();
         check($sformatf("vec%0d_cnt", i), stall_cnt, vecs[i].sc);
      end

      // memory read acked after three stalled cycles; branch/load-use ignored
      drive(1, 8, 8, 0, 1, 1, 0, 0);
      #2; check("memwait_c1", outs, 8'h80);
      step();
      #2; check("memwait_c2", outs, 8'h80);
      step();
      #2; check("memwait_c3", outs, 8'h80);
      step();
      dmem_ack = 1'b1;
      #2; check("memwait_ack", outs, 8'hF8);
      step();
      check("memwait_cnt", stall_cnt, 16'd6);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #2; check("memwait_after", outs, 8'h78);
      step();

      // write timeout with TIMEOUT=4
      drive(0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 1; i <= 3; i++) begin
         #2; check($sformatf("tmo_c%0d", i), outs, 8'h80);
         step();
      end
      #2;
      check("tmo_c4_rstEXMEM", outs, 8'h81);
      check("tmo_c4_err_low", err, 0);
      step();
      check("tmo_err", err, 1);
      check("tmo_cnt", stall_cnt, 16'd10);
      drive(1, 8, 8, 0, 1, 1, 1, 1);
      for (int i = 0; i < 3; i++) begin
         #2; check($sformatf("err_hold%0d", i), outs, 8'h00);
         step();
      end
      check("err_sticky", err, 1);
      check("err_cnt_frozen", stall_cnt, 16'd10);

      // asynchronous reset in ERR
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      rst = 1'b0;
      #1;
      check("rst_err_err", err, 0);
      check("rst_err_cnt", stall_cnt, 0);
      check("rst_err_outs", outs, 8'h00);
      #2;
      rst = 1'b1;
      step();
      #2; check("rst_err_run", outs, 8'h78);
      step();

      // asynchronous reset mid-MEMWAIT
      drive(0, 0, 0, 0, 0, 1, 0, 0);
      step();
      EXMEM_MemR = 1'b0;
      #2; check("mw_state_req", outs, 8'h80);
      rst = 1'b0;
      #1;
      check("mw_rst_outs", outs, 8'h00);
      #2;
      rst = 1'b1;
      step();
      #2; check("mw_rst_run", outs, 8'h78);
      check("mw_rst_cnt", stall_cnt, 0);
      step();

      // saturation of stall_cnt via sustained load-use stalls
      drive(1, 9, 9, 0, 0, 0, 0, 0);
      for (int i = 0; i < 65534; i++) step();
      check("sat_fffe", stall_cnt, 16'hFFFE);
      for (int i = 0; i < 3; i++) step();
      #2; check("sat_outs", outs, 8'h1A);
      check("sat_ffff", stall_cnt, 16'hFFFF);
      step();
      check("sat_hold", stall_cnt, 16'hFFFF);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
